grn_attractor_ctrl: RTL

//  Upstream controller for the per-node GRN update cells of one network.

---
 rtl/grn_attractor_ctrl_pkg.sv | 18 +
 rtl/grn_attractor_ctrl_step_counter.sv | 37 +++
 rtl/grn_attractor_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/grn_attractor_ctrl_pkg.sv
// Shared types and defaults for the GRN attractor sweep controller.
// State encodings are fixed 3-bit values so waveforms stay readable across builds.
package grn_attractor_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_PERIOD = 3'd3,
        ST_OUT    = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    localparam int DEF_N_NODES   = 8;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_MAX_STEPS = 4096;

endpackage

// File: rtl/grn_attractor_ctrl_step_counter.sv
// Saturating step counter used for both the detection count (k) and the period count (p).
// Holds at limit_i so the controller can compare against the limit without wrap concerns.
module grn_attractor_ctrl_step_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_limit_o
);

    logic [CNT_W-1:0] count_q, count_d;

    assign at_limit_o = (count_q == limit_i);
    assign count_o    = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !at_limit_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/grn_attractor_ctrl.sv
// Sweeps a range of initial network states, running Floyd cycle detection on the node cells
// for each one and reporting steps-to-detection, attractor period and timeout per state.
module grn_attractor_ctrl
    import grn_attractor_ctrl_pkg::*;
#(
    parameter int N_NODES   = DEF_N_NODES,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_STEPS = DEF_MAX_STEPS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] first_state,
    input  logic [N_NODES-1:0] last_state,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_init,
    output logic [CNT_W-1:0]   res_steps,
    output logic [CNT_W-1:0]   res_period,
    output logic               res_timeout,
    output logic               busy,
    output logic               done
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0] RUN_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(1);

    state_e             state_q, state_d;
    logic [N_NODES-1:0] cur_q, cur_d;
    logic [N_NODES-1:0] last_q, last_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               timeout_q, timeout_d;

    logic [CNT_W-1:0]   k_cnt, p_cnt;
    logic               k_lim, p_lim;
    logic               nodes_eq, match_run, match_per;

    grn_attractor_ctrl_step_counter #(.CNT_W(CNT_W)) u_k_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (state_q == ST_LOAD),
        .enable_i   (state_q == ST_RUN),
        .limit_i    (LIMIT),
        .count_o    (k_cnt),
        .at_limit_o (k_lim)
    );

    // p is held at zero outside PERIOD so it reads 0 on the entry cycle.
    grn_attractor_ctrl_step_counter #(.CNT_W(CNT_W)) u_p_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (state_q != ST_PERIOD),
        .enable_i   (state_q == ST_PERIOD),
        .limit_i    (LIMIT),
        .count_o    (p_cnt),
        .at_limit_o (p_lim)
    );

    assign nodes_eq  = (s0_vec == s1_vec);
    assign match_run = (state_q == ST_RUN)    && (k_cnt >= RUN_MIN) && nodes_eq;
    assign match_per = (state_q == ST_PERIOD) && (p_cnt >= PER_MIN) && nodes_eq;

    assign reset_nos   = (state_q == ST_LOAD);
    assign start_s0    = (state_q == ST_RUN) && !match_run;
    assign start_s1    = ((state_q == ST_RUN) && !match_run) || ((state_q == ST_PERIOD) && !match_per);
    assign init_state  = cur_q;
    assign res_valid   = (state_q == ST_OUT);
    assign res_init    = cur_q;
    assign res_steps   = steps_q;
    assign res_period  = period_q;
    assign res_timeout = timeout_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        steps_d   = steps_q;
        period_d  = period_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_d   = first_state;
                    last_d  = last_state;
                    state_d = (last_state < first_state) ? ST_FIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                steps_d   = '0;
                period_d  = '0;
                timeout_d = 1'b0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (match_run) begin
                    steps_d = k_cnt;
                    state_d = ST_PERIOD;
                end else if (k_lim) begin
                    steps_d   = k_cnt;
                    period_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_OUT;
                end
            end
            ST_PERIOD: begin
                if (match_per) begin
                    period_d = p_cnt;
                    state_d  = ST_OUT;
                end else if (p_lim) begin
                    period_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_OUT;
                end
            end
            ST_OUT: begin
                // Terminating on cur==last before incrementing keeps the all-ones state from wrapping.
                if (res_ready) begin
                    if (cur_q == last_q) begin
                        state_d = ST_FIN;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            steps_q   <= '0;
            period_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            steps_q   <= steps_d;
            period_q  <= period_d;
            timeout_q <= timeout_d;
        end
    end

    // The sweep bound is only read after IDLE has loaded it, so it needs no reset.
    always_ff @(posedge clk) begin
        last_q <= last_d;
    end

endmodule
